// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared RV32M opcodes, controller states and constants
package rv32m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/rv32m_special.sv
// rtl/rv32m_special.sv - resolves divide-by-zero and signed-overflow results
// without involving the iterative unit.
module rv32m_special
  import rv32m_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic is_divrem;
  logic is_rem;
  logic is_signed;

  // funct3[2] selects the div/rem group, [1] picks rem, [0] picks unsigned.
  assign is_divrem = funct3[2];
  assign is_rem    = funct3[1];
  assign is_signed = ~funct3[0];

  always_comb begin
    is_special     = 1'b0;
    special_result = '0;
    if (is_divrem) begin
      if (op_b == '0) begin
        is_special     = 1'b1;
        special_result = is_rem ? op_a : ALL_ONES;
      end else if (is_signed && op_a == INT_MIN && op_b == ALL_ONES) begin
        is_special     = 1'b1;
        special_result = is_rem ? '0 : INT_MIN;
      end
    end
  end

endmodule

// File: rtl/rv32m_ctrl.sv
// rtl/rv32m_ctrl.sv - issue/response controller for the iterative rv32m unit,
// with special-case bypass and a one-entry result cache.
module rv32m_ctrl
  import rv32m_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        mdu_start,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic [2:0]  mdu_m,
  input  logic        mdu_finish,
  input  logic [31:0] mdu_r,
  input  logic        mdu_div0
);

  ctrl_state_t state, state_next;

  logic        is_special;
  logic [31:0] special_result;

  logic        cache_valid;
  logic [2:0]  cache_f3;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [31:0] cache_r;
  logic        cache_hit;

  logic        accept;
  logic        unit_done;
  logic        unused_div0;

  assign unused_div0 = mdu_div0;

  rv32m_special u_special (
    .funct3         (funct3),
    .op_a           (op_a),
    .op_b           (op_b),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign cache_hit = cache_valid && (cache_f3 == funct3) &&
                     (cache_a == op_a) && (cache_b == op_b);

  assign accept    = (state == IDLE) && req && !flush;
  assign unit_done = (state == WAIT) && mdu_finish && !flush;

  assign done      = (state == DONE);
  assign mdu_start = (state == ISSUE);
  assign stall     = req && !done && !rst;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (is_special || cache_hit) ? DONE : ISSUE;
      // A finish level seen during ISSUE belongs to the previous operation.
      ISSUE:   state_next = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush)           state_next = IDLE;
        else if (mdu_finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      result      <= '0;
      mdu_a       <= '0;
      mdu_b       <= '0;
      mdu_m       <= '0;
      cache_valid <= 1'b0;
      cache_f3    <= '0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_r     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (is_special) begin
          result <= special_result;
        end else if (cache_hit) begin
          result <= cache_r;
        end else begin
          mdu_a <= op_a;
          mdu_b <= op_b;
          mdu_m <= funct3;
        end
      end
      // Only unit results are cached; bypassed specials never touch the entry.
      if (unit_done) begin
        result      <= mdu_r;
        cache_valid <= 1'b1;
        cache_f3    <= mdu_m;
        cache_a     <= mdu_a;
        cache_b     <= mdu_b;
        cache_r     <= mdu_r;
      end
    end
  end

endmodule

// File: tb/tb_rv32m_ctrl.sv
// tb/tb_rv32m_ctrl.sv - directed self-checking bench for rv32m_ctrl with a
// behavioural multi-cycle multiply/divide unit.
module tb_rv32m_ctrl;
  import rv32m_pkg::*;

  logic        clk;
  logic        rst;
  logic        req;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        mdu_start;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic [2:0]  mdu_m;
  logic        mdu_finish;
  logic [31:0] mdu_r;
  logic        mdu_div0;

  int n_cmp;
  int n_fail;

  int          unit_cnt;
  logic [31:0] unit_res;

  rv32m_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .funct3     (funct3),
    .op_a       (op_a),
    .op_b       (op_b),
    .flush      (flush),
    .stall      (stall),
    .done       (done),
    .result     (result),
    .mdu_start  (mdu_start),
    .mdu_a      (mdu_a),
    .mdu_b      (mdu_b),
    .mdu_m      (mdu_m),
    .mdu_finish (mdu_finish),
    .mdu_r      (mdu_r),
    .mdu_div0   (mdu_div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdu_calc(input logic [2:0] m, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] pa, pb, p;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    case (m)
      3'b000:  begin p = pa * pb; return p[31:0]; end
      3'b001:  begin p = pa * pb; return p[63:32]; end
      3'b010:  begin p = pa * {32'b0, b}; return p[63:32]; end
      3'b011:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100:  return $signed(a) / $signed(b);
      3'b101:  return a / b;
      3'b110:  return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // Unit model: finish rises 34 cycles after start (66 for mulh), stays high until next start.
  always @(posedge clk) begin
    if (rst) begin
      mdu_finish <= 1'b0;
      unit_cnt   <= 0;
    end else if (mdu_start) begin
      mdu_finish <= 1'b0;
      unit_cnt   <= (mdu_m == 3'b001) ? 65 : 33;
      unit_res   <= mdu_calc(mdu_m, mdu_a, mdu_b);
    end else if (unit_cnt != 0) begin
      unit_cnt <= unit_cnt - 1;
      if (unit_cnt == 1) mdu_finish <= 1'b1;
    end
  end
  assign mdu_r    = unit_res;
  assign mdu_div0 = 1'b0;

  task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat, input int exp_starts,
                         input string nm);
    int lat, starts, stall_bad;
    lat = -1; starts = 0; stall_bad = 0;
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; req = 1'b1;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (mdu_start) starts++;
      if (done) begin
        lat = k;
        if (stall !== 1'b0) stall_bad++;
        break;
      end
      if (stall !== 1'b1) stall_bad++;
    end
    req = 1'b0;
    n_cmp++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat);
    end
    n_cmp++;
    if (result !== exp_r) begin
      n_fail++; $display("FAIL %s_result: got %h expected %h", nm, result, exp_r);
    end
    n_cmp++;
    if (starts !== exp_starts) begin
      n_fail++; $display("FAIL %s_starts: got %0d expected %0d", nm, starts, exp_starts);
    end
    n_cmp++;
    if (stall_bad !== 0) begin
      n_fail++; $display("FAIL %s_stall: got %0d bad cycles expected 0", nm, stall_bad);
    end
    if (exp_starts == 1) begin
      n_cmp++;
      if ({mdu_m, mdu_a, mdu_b} !== {f3, a, b}) begin
        n_fail++;
        $display("FAIL %s_operands: got %h/%h/%h expected %h/%h/%h", nm, mdu_m, mdu_a, mdu_b, f3, a, b);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({done, mdu_start, stall} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {done, mdu_start, stall});
    end
    n_cmp++;
    if ({result, mdu_a, mdu_b, mdu_m} !== 99'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h %h %h %h expected zeros", result, mdu_a, mdu_b, mdu_m);
    end
  endtask

  task automatic test_mul();
    run_req(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 36, 1, "mul");
    run_req(F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 68, 1, "mulh");
  endtask

  task automatic test_bypass();
    run_req(F3_DIV, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0, "div0");
    run_req(F3_REM, 32'd100, 32'd0, 32'h0000_0064, 1, 0, "rem0");
    run_req(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    run_req(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, "rem_ovf");
  endtask

  task automatic test_cache();
    run_req(F3_DIVU, 32'd1000, 32'd7, 32'd142, 36, 1, "divu_miss");
    run_req(F3_DIVU, 32'd1000, 32'd7, 32'd142, 1, 0, "divu_hit");
    run_req(F3_REMU, 32'd1000, 32'd7, 32'd6, 36, 1, "remu_miss");
  endtask

  task automatic abort_mid(input logic use_rst, input string nm);
    int dones, starts;
    dones = 0; starts = 0;
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd9; op_b = 32'd9; req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (mdu_start) starts++;
    end
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    #1;
    if (use_rst) begin
      n_cmp++;
      if (stall !== 1'b0) begin
        n_fail++; $display("FAIL %s_stall_in_rst: got %b expected 0", nm, stall);
      end
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; req = 1'b0;
    if (use_rst) begin
      n_cmp++;
      if ({result, mdu_a, mdu_b, mdu_m, mdu_start} !== 100'd0) begin
        n_fail++;
        $display("FAIL %s_regs_cleared: got %h %h %h %h %b expected zeros", nm, result, mdu_a,
                 mdu_b, mdu_m, mdu_start);
      end
    end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) dones++;
      if (mdu_start) starts++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL %s_no_done: got %0d done cycles expected 0", nm, dones);
    end
    n_cmp++;
    if (starts !== 1) begin
      n_fail++; $display("FAIL %s_starts: got %0d expected 1", nm, starts);
    end
  endtask

  task automatic test_flush();
    int dones;
    dones = 0;
    // Flush while idle: request must not be accepted.
    @(negedge clk);
    funct3 = F3_DIV; op_a = 32'd5; op_b = 32'd0; req = 1'b1; flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || mdu_start) dones++;
    end
    req = 1'b0; flush = 1'b0;
    n_cmp++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL idle_flush: got %0d active cycles expected 0", dones);
    end
    abort_mid(1'b0, "flush_wait");
    run_req(F3_REMU, 32'd1000, 32'd7, 32'd6, 1, 0, "flush_cache_kept");
    run_req(F3_MUL, 32'd3, 32'd5, 32'd15, 36, 1, "after_flush");
  endtask

  task automatic test_reset_mid();
    abort_mid(1'b1, "rst_wait");
    run_req(F3_MUL, 32'd3, 32'd5, 32'd15, 36, 1, "rst_miss");
  endtask

  task automatic test_done_flush();
    int lat;
    lat = -1;
    @(negedge clk);
    funct3 = F3_MUL; op_a = 32'd6; op_b = 32'd7; req = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    flush = 1'b1; req = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (lat !== 36) begin
      n_fail++; $display("FAIL done_flush_latency: got %0d expected 36", lat);
    end
    n_cmp++;
    if (result !== 32'd42) begin
      n_fail++; $display("FAIL done_flush_result: got %h expected %h", result, 32'd42);
    end
    run_req(F3_MUL, 32'd6, 32'd7, 32'd42, 1, 0, "done_flush_cached");
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; req = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_mul();
    test_bypass();
    test_cache();
    test_flush();
    test_reset_mid();
    test_done_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32m_ctrl.md
# rv32m_ctrl

Issue/response controller that drives the iterative `rv32m` multiply/divide unit on behalf of the CPU execute stage. It accepts one RV32M request at a time and holds the pipeline stalled while the request is in flight. It resolves RISC-V special cases (divide by zero, signed overflow) without using the unit. It also short-circuits exact repeats through a one-entry result cache, and returns a one-cycle `done` pulse with the architectural result.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  1  CPU request valid. Held high with stable `funct3`/`op_a`/`op_b` until `done`.
- `funct3`  in  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `op_a`  in  32  rs1 value.
- `op_b`  in  32  rs2 value.
- `flush`  in  1  abort the current request; no `done` is produced.
- `stall`  out  1  combinational `req && !done && !rst`.
- `done`  out  1  one-cycle result-valid pulse.
- `result`  out  32  rd value; valid when `done`=1 and held until the next `done`.
- `mdu_start`  out  1  one-cycle start pulse to the unit.
- `mdu_a`, `mdu_b`  out  32 each  latched operands.
- `mdu_m`  out  3  op code; equal to `funct3`.
- `mdu_finish`  in  1  unit completion level; stays high until the next start.
- `mdu_r`  in  32  unit result; valid while `mdu_finish`=1.
- `mdu_div0`  in  1  unused; never 1 while in WAIT.

## Operation
States:
- IDLE
- ISSUE: `mdu_start`=1.
- WAIT
- DONE: `done`=1.

IDLE decision rules, when `req`=1, in priority order:
- `flush` → stay in IDLE; the request is not accepted.
- Div/rem with `op_b`==0 → DONE. Result is 0xFFFFFFFF for div/divu, and `op_a` for rem/remu.
- Signed div/rem (100/110) with `op_a`==0x80000000 and `op_b`==0xFFFFFFFF → DONE. Result is 0x80000000 for div, 0 for rem.
- Cache hit (valid, and `funct3`, `op_a`, `op_b` all equal) → DONE with the cached result.
- Otherwise → latch `mdu_a`/`mdu_b`/`mdu_m`, go to ISSUE.

Other transitions:
- ISSUE → WAIT unconditionally. `mdu_finish` is ignored during ISSUE, because it may be stale from the previous operation.
- WAIT: when `mdu_finish`=1, latch `mdu_r` into `result` and the cache entry, set cache valid, go to DONE.
- DONE → IDLE. The CPU drops `req` or presents a new instruction on the cycle after `done`. A re-presented identical request is a cache hit.
- `flush` in ISSUE, WAIT or DONE → IDLE next cycle. `done` is suppressed and the cache is not updated. The unit keeps running and is resynchronised by the next `mdu_start`.

Cache rules:
- One entry: funct3, a, b, result, valid.
- Updated only by unit results; special-case results are never cached.

## Timing
- Reset values: state IDLE, `done`=0, `result`=0, `mdu_start`=0, `mdu_a`=`mdu_b`=0, `mdu_m`=0, cache valid=0.
- `rst` mid-operation → IDLE next cycle with the reset values above; no `done`.
- Request accepted at the edge ending cycle T0.
- Bypass or cache hit: `done` in T1 (latency 1).
- Unit path:
  - `mdu_start` high in T1 only; WAIT from T2.
  - mul/mulhsu/mulhu/div/divu/rem/remu: `mdu_finish` is seen in T35 and `done` is in T36 (latency 36).
  - mulh: `mdu_finish` is seen in T67 and `done` is in T68 (latency 68).
- `mdu_start` is never high for two consecutive cycles and is never high outside ISSUE.
- `done` and `flush` in the same cycle: `done` still counts; the flush takes no effect on that request.

## Structure
- Shared package `rv32m_pkg` holds:
  - funct3 constants F3_MUL … F3_REMU
  - the state enum (IDLE/ISSUE/WAIT/DONE)
  - INT_MIN = 32'h80000000 and ALL_ONES
- One sub-module, `rv32m_special`: purely combinational. Inputs `funct3`, `op_a`, `op_b`; outputs `is_special` and `special_result` (the div-by-zero and overflow rules).
- FSM and cache live in `rv32m_ctrl`.

## Test plan
- mul, a=7, b=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` at latency 36, exactly one `mdu_start` cycle, `stall` high T0–T35.
- mulh, a=b=0x80000000 → `result`=0x40000000, latency 68.
- div, a=100, b=0 → 0xFFFFFFFF at latency 1, `mdu_start` never asserted. Then rem, a=100, b=0 → 0x00000064, latency 1.
- div, a=0x80000000, b=0xFFFFFFFF → 0x80000000 at latency 1. Then rem with the same operands → 0, latency 1.
- divu, a=1000, b=7 → 142, latency 36. Repeat the same request → 142, latency 1 (hit). Then remu, a=1000, b=7 → 6, latency 36 (miss).
- mul 9×9 flushed in WAIT cycle 10 → no `done`, cache unchanged. Then mul 3×5 → 15 at latency 36. Repeat the 3×5 scenario with `rst` instead of `flush`; the next request after reset misses the cache.
